// File: rtl/MD_pkg.sv
// Shared widths, cell-ID encodings and scheduler types for the MD cell datapath.
package MD_pkg;
  localparam int CELL_ID_WIDTH        = 2;
  localparam int GLOBAL_CELL_ID_WIDTH = 3;

  localparam logic [CELL_ID_WIDTH-1:0] CID_MINUS = 2'b01;
  localparam logic [CELL_ID_WIDTH-1:0] CID_HOME  = 2'b10;
  localparam logic [CELL_ID_WIDTH-1:0] CID_PLUS  = 2'b11;

  localparam int NB_IDX_WIDTH = 5;
  localparam int NB_HOME_IDX  = 13;
  localparam int NB_LAST_IDX  = 26;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } nb_state_e;
endpackage

// File: rtl/gcid_wrap_rt.sv
// Maps a runtime home global cell ID plus a local minus/home/plus ID to the
// periodic-boundary-wrapped neighbor global cell ID along one dimension.
module gcid_wrap_rt
  import MD_pkg::*;
#(
  parameter int GDIM = 4
) (
  input  logic [GLOBAL_CELL_ID_WIDTH-1:0] home,
  input  logic [CELL_ID_WIDTH-1:0]        cid,
  output logic [GLOBAL_CELL_ID_WIDTH-1:0] gcid
);
  localparam int GW = GLOBAL_CELL_ID_WIDTH;
  localparam logic [GW-1:0] G_MAX = GW'(GDIM - 1);

  // Wrap is chosen by comparison against the edges, never by relying on overflow.
  always_comb begin
    gcid = home;
    case (cid)
      CID_MINUS: gcid = (home == '0)    ? G_MAX : home - GW'(1);
      CID_PLUS:  gcid = (home == G_MAX) ? '0    : home + GW'(1);
      default:   gcid = home;
    endcase
  end
endmodule

// File: rtl/neighbor_cell_scheduler.sv
// Handshaked iterator over the 27-cell (or 14-cell half) neighbor shell of one
// home cell, emitting local cell IDs and wrapped global cell IDs per entry.
module neighbor_cell_scheduler
  import MD_pkg::*;
#(
  parameter int GDIM_X     = 4,
  parameter int GDIM_Y     = 4,
  parameter int GDIM_Z     = 4,
  parameter bit HALF_SHELL = 1'b1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_start,
  input  logic [GLOBAL_CELL_ID_WIDTH-1:0] i_home_gcid_x,
  input  logic [GLOBAL_CELL_ID_WIDTH-1:0] i_home_gcid_y,
  input  logic [GLOBAL_CELL_ID_WIDTH-1:0] i_home_gcid_z,
  output logic                            o_valid,
  input  logic                            i_ready,
  output logic [CELL_ID_WIDTH-1:0]        o_cid_x,
  output logic [CELL_ID_WIDTH-1:0]        o_cid_y,
  output logic [CELL_ID_WIDTH-1:0]        o_cid_z,
  output logic [GLOBAL_CELL_ID_WIDTH-1:0] o_gcid_x,
  output logic [GLOBAL_CELL_ID_WIDTH-1:0] o_gcid_y,
  output logic [GLOBAL_CELL_ID_WIDTH-1:0] o_gcid_z,
  output logic                            o_last,
  output logic                            o_busy,
  output logic                            o_done,
  output logic                            o_err
);
  localparam int GW  = GLOBAL_CELL_ID_WIDTH;
  localparam int GWP = GW + 1;
  localparam logic [NB_IDX_WIDTH-1:0] LAST_IDX  = NB_IDX_WIDTH'(NB_LAST_IDX);
  localparam logic [NB_IDX_WIDTH-1:0] START_IDX = HALF_SHELL ? NB_IDX_WIDTH'(NB_HOME_IDX) : '0;
  // Index 13 is the home cell itself, i.e. offset 1 on every axis.
  localparam logic [1:0]              START_D   = HALF_SHELL ? 2'd1 : 2'd0;

  nb_state_e                      state, state_nxt;
  logic [NB_IDX_WIDTH-1:0]        idx, idx_nxt;
  logic [2:0][1:0]                d, d_nxt;
  logic [2:0][GW-1:0]             home, home_nxt, home_in;
  logic [2:0][CELL_ID_WIDTH-1:0]  cid_nxt, cid_q;
  logic [2:0][GW-1:0]             wrap_out, gcid_nxt, gcid_q;
  logic [2:0]                     home_bad;
  logic                           err_nxt;
  logic                           valid_q, last_q, busy_q, done_q, err_q;

  assign home_in = {i_home_gcid_z, i_home_gcid_y, i_home_gcid_x};

  for (genvar g = 0; g < 3; g++) begin : g_dim
    localparam int GDIM = (g == 0) ? GDIM_X : (g == 1) ? GDIM_Y : GDIM_Z;
    assign home_bad[g] = {1'b0, home_in[g]} >= GWP'(GDIM);
    gcid_wrap_rt #(.GDIM(GDIM)) u_wrap (
      .home (home_nxt[g]),
      .cid  (cid_nxt[g]),
      .gcid (wrap_out[g])
    );
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    d_nxt     = d;
    home_nxt  = home;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) begin
          if (|home_bad) begin
            err_nxt = 1'b1;
          end else begin
            state_nxt = RUN;
            idx_nxt   = START_IDX;
            d_nxt     = {3{START_D}};
            home_nxt  = home_in;
          end
        end
      end
      RUN: begin
        if (i_ready) begin
          if (idx == LAST_IDX) begin
            state_nxt = DONE;
          end else begin
            idx_nxt = idx + NB_IDX_WIDTH'(1);
            // x fastest, carry into y then z
            if (d[0] != 2'd2) begin
              d_nxt[0] = d[0] + 2'd1;
            end else begin
              d_nxt[0] = 2'd0;
              if (d[1] != 2'd2) begin
                d_nxt[1] = d[1] + 2'd1;
              end else begin
                d_nxt[1] = 2'd0;
                d_nxt[2] = d[2] + 2'd1;
              end
            end
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    for (int g = 0; g < 3; g++)
      cid_nxt[g] = (state_nxt == RUN) ? d_nxt[g] + 2'd1 : 2'b00;
  end

  assign gcid_nxt = (state_nxt == RUN) ? wrap_out : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      d       <= '0;
      home    <= '0;
      cid_q   <= '0;
      gcid_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      d       <= d_nxt;
      home    <= home_nxt;
      cid_q   <= cid_nxt;
      gcid_q  <= gcid_nxt;
      valid_q <= (state_nxt == RUN);
      last_q  <= (state_nxt == RUN) && (idx_nxt == LAST_IDX);
      busy_q  <= (state_nxt != IDLE);
      done_q  <= (state_nxt == DONE);
      err_q   <= err_nxt;
    end
  end

  assign o_valid  = valid_q;
  assign o_last   = last_q;
  assign o_busy   = busy_q;
  assign o_done   = done_q;
  assign o_err    = err_q;
  assign o_cid_x  = cid_q[0];
  assign o_cid_y  = cid_q[1];
  assign o_cid_z  = cid_q[2];
  assign o_gcid_x = gcid_q[0];
  assign o_gcid_y = gcid_q[1];
  assign o_gcid_z = gcid_q[2];
endmodule
